avmm_lvds_bridge_rx_gearbox_fifo: RTL and testbench
===================================================

Name: avmm_lvds_bridge_rx_gearbox_fifo

Overview:
Single-clock deserialising receive FIFO for the AVMM-LVDS bridge, implemented in plain RTL with no vendor IP. It packs FACTOR narrow words from the LVDS receive path into one DATA_W word and buffers SIZE wide words. Compared with the earlier mixed-width FIFO it adds run-time selectable read mode, a partial-word flush with zero padding, a full flag, and sticky overflow/underflow flags. It sits between the receive deframer and the AVMM master, both in the same clock domain.

Parameters:
DATA_W, 32, wide (read) word width; power of 2.
FACTOR, 4, narrow words per wide word; power of 2, 1..DATA_W. FACTOR=1 means plain FIFO, no assembly.
SIZE, 16, depth in wide words; power of 2, >=2.
SHOWAHEAD, 0, 0 = normal mode (q_o valid after rdreq_i); 1 = show-ahead (q_o presents head word while !rdempty_o).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
data_i  in  DATA_W/FACTOR  narrow write data
wrreq_i  in  1  write narrow word
flush_i  in  1  commit partial wide word, zero-padded
wrfull_o  out  1  next lane-completing write would overflow
rdreq_i  in  1  read/acknowledge one wide word
q_o  out  DATA_W  read data
rdempty_o  out  1  no complete wide word stored
rdusedw_o  out  $clog2(SIZE)+1  complete wide words stored (0..SIZE)
ovf_o  out  1  sticky: write or flush dropped
udf_o  out  1  sticky: rdreq_i while empty

Behaviour:
- Reset (rst_i=1 at a clock edge): lane counter 0, assembly register 0, pointers 0, rdusedw_o=0, rdempty_o=1, wrfull_o=0, q_o=0, ovf_o=0, udf_o=0. Any partial word is discarded. Reset overrides all other inputs in that cycle.
- Lane order: the first narrow word after a commit occupies bits [DATA_W/FACTOR-1:0]. Later words fill successively higher lanes.
- Commit: wrreq_i with lane counter = FACTOR-1 writes {data_i, assembled lanes} to storage. The lane counter wraps to 0.
- Commit latency: if the commit happens at edge N, then after edge N rdusedw_o has incremented and rdempty_o=0. The word is readable from cycle N+1.
- Flush: flush_i with lane counter != 0 commits the assembled lanes with the unfilled upper lanes set to 0. If wrreq_i is also asserted in that cycle, data_i is placed in the current lane first, then the flush applies.
  - flush_i with lane counter 0 and no wrreq_i: no-op.
  - flush_i coinciding with a natural lane-completing commit: a single commit occurs.
- Full: wrfull_o = (rdusedw_o==SIZE). The output is registered and updated with the pointers.
  - Narrow writes to non-final lanes are accepted while full.
  - A commit or flush attempted while full is dropped: storage unchanged, lane counter and assembly cleared, ovf_o set.
- Read, SHOWAHEAD=0: rdreq_i while !rdempty_o pops the head; q_o updates on the same edge, so the data is valid the cycle after rdreq_i. q_o holds its value otherwise.
- Read, SHOWAHEAD=1: q_o equals the head word whenever !rdempty_o; rdreq_i consumes it. While empty, q_o holds the last value.
- Underflow: rdreq_i while rdempty_o=1 is ignored and sets udf_o. A commit in the same cycle into an empty FIFO does not satisfy that read.
- Simultaneous commit and pop with rdusedw_o between 1 and SIZE: count unchanged, both pointers advance. At full, the pop frees a slot first, so the commit is accepted and no overflow occurs.
- Pointers are $clog2(SIZE) bits and wrap modulo SIZE. The count is tracked separately and never exceeds SIZE.
- ovf_o and udf_o clear only on rst_i.

Test Plan:
1. DATA_W=32, FACTOR=4: write 0x11,0x22,0x33,0x44 on consecutive cycles -> cycle after the last write rdusedw_o=1, rdempty_o=0. rdreq -> q_o=0x44332211 next cycle (SHOWAHEAD=0).
2. Write 0xAA,0xBB, then pulse flush_i -> one word stored, q_o=0x0000BBAA. Also wrreq_i=0xCC together with flush_i after one byte 0xDD -> q_o=0x0000CCDD.
3. SIZE=16: commit 16 words (values 0..15 in lane 0) -> wrfull_o=1, rdusedw_o=16. A 17th full word -> ovf_o=1, count stays 16. Read all 16 -> values 0..15 in order, rdempty_o=1.
4. rdreq_i on empty FIFO after reset -> udf_o=1, rdusedw_o stays 0, q_o stays 0.
5. With rdusedw_o=3, commit and rdreq_i in the same cycle -> rdusedw_o=3. At rdusedw_o=16, the same -> rdusedw_o=16, ovf_o=0.
6. SHOWAHEAD=1: commit 0xDEADBEEF -> q_o=0xDEADBEEF with no rdreq. Assert rst_i after 2 of 4 bytes -> rdempty_o=1, and the next 4 bytes assemble from lane 0.

Source files
------------

// File: rtl/avmm_lvds_bridge_rx_gearbox_fifo.sv
// Receive gearbox FIFO: packs FACTOR narrow LVDS words into one DATA_W word and
// buffers SIZE wide words, with flush, full flag and sticky overflow/underflow.
module avmm_lvds_bridge_rx_gearbox_fifo #(
    parameter int DATA_W    = 32,
    parameter int FACTOR    = 4,
    parameter int SIZE      = 16,
    parameter int SHOWAHEAD = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W/FACTOR-1:0]   data_i,
    input  logic                       wrreq_i,
    input  logic                       flush_i,
    output logic                       wrfull_o,
    input  logic                       rdreq_i,
    output logic [DATA_W-1:0]          q_o,
    output logic                       rdempty_o,
    output logic [$clog2(SIZE):0]      rdusedw_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int NW = DATA_W / FACTOR;
    localparam int LW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

    logic [LW-1:0]     lane_q, lane_d;
    logic [DATA_W-1:0] asm_q, asm_d, word;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] q_q, q_d, head;
    logic              last_lane, commit, pop, accept;

    logic [DATA_W-1:0] mem [SIZE];

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        lane_d  = lane_q;
        asm_d   = asm_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        q_d     = q_q;
        head    = mem[rptr_q];

        // Assembly is kept zeroed above the fill point, so a flush pads for free.
        word = asm_q;
        if (wrreq_i) begin
            word[lane_q*NW +: NW] = data_i;
        end

        last_lane = (lane_q == LW'(FACTOR - 1));
        commit    = (wrreq_i && last_lane) || (flush_i && (wrreq_i || lane_q != '0));
        pop       = rdreq_i && !empty_q;
        // A same-cycle pop frees a slot before the commit is judged.
        accept    = commit && (!full_q || pop);

        if (commit) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (wrreq_i) begin
            lane_d = lane_q + 1'b1;
            asm_d  = word;
        end

        if (commit && !accept) begin
            ovf_d = 1'b1;
        end
        if (rdreq_i && empty_q) begin
            udf_d = 1'b1;
        end

        if (accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            q_d    = head;
        end

        cnt_d   = cnt_q + CW'(accept) - CW'(pop);
        full_d  = (cnt_d == CW'(SIZE));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            lane_q  <= '0;
            asm_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            q_q     <= q_d;
        end
    end

    // NOTE: storage is not reset; empty_q masks stale contents from every output.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            mem[wptr_q] <= word;
        end
    end

    // In show-ahead mode q_q holds the last consumed word for display while empty.
    assign q_o       = (SHOWAHEAD != 0 && !empty_q) ? head : q_q;
    assign wrfull_o  = full_q;
    assign rdempty_o = empty_q;
    assign rdusedw_o = cnt_q;
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;

endmodule

// File: tb/tb_avmm_lvds_bridge_rx_gearbox_fifo.sv
// Directed bench for the receive gearbox FIFO: normal-mode instance plus a
// show-ahead instance, all expected values hand-computed.
module tb_avmm_lvds_bridge_rx_gearbox_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Normal-mode instance
    logic        rst = 1'b1, wr = 1'b0, fl = 1'b0, rd = 1'b0;
    logic [7:0]  d = '0;
    logic        full, empty, ovf, udf;
    logic [31:0] q;
    logic [4:0]  used;

    // Show-ahead instance
    logic        s_rst = 1'b1, s_wr = 1'b0, s_fl = 1'b0, s_rd = 1'b0;
    logic [7:0]  s_d = '0;
    logic        s_full, s_empty, s_ovf, s_udf;
    logic [31:0] s_q;
    logic [4:0]  s_used;

    int n_total = 0;
    int n_bad   = 0;

    avmm_lvds_bridge_rx_gearbox_fifo #(
        .DATA_W(32), .FACTOR(4), .SIZE(16), .SHOWAHEAD(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .data_i(d), .wrreq_i(wr), .flush_i(fl),
        .wrfull_o(full), .rdreq_i(rd), .q_o(q), .rdempty_o(empty),
        .rdusedw_o(used), .ovf_o(ovf), .udf_o(udf)
    );

    avmm_lvds_bridge_rx_gearbox_fifo #(
        .DATA_W(32), .FACTOR(4), .SIZE(16), .SHOWAHEAD(1)
    ) dut_sa (
        .clk_i(clk), .rst_i(s_rst), .data_i(s_d), .wrreq_i(s_wr), .flush_i(s_fl),
        .wrfull_o(s_full), .rdreq_i(s_rd), .q_o(s_q), .rdempty_o(s_empty),
        .rdusedw_o(s_used), .ovf_o(s_ovf), .udf_o(s_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, input logic [7:0] dd, input logic f, input logic r);
        wr = w; d = dd; fl = f; rd = r;
        tick();
        wr = 1'b0; fl = 1'b0; rd = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] v);
        for (int i = 0; i < 4; i++) cyc(1'b1, v[8*i +: 8], 1'b0, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check(tag, q, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic s_cyc(input logic w, input logic [7:0] dd, input logic r);
        s_wr = w; s_d = dd; s_rd = r;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        check("rst_used",  32'(used),  32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_q",     q,          32'h0);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_udf",   32'(udf),   32'd0);

        // Underflow on empty, and a same-cycle commit does not satisfy the read
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf_set",   32'(udf),  32'd1);
        check("udf_used",  32'(used), 32'd0);
        check("udf_q",     q,         32'h0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b1, 8'h04, 1'b0, 1'b1);
        check("udf_cmt_used", 32'(used),  32'd1);
        check("udf_cmt_q",    q,          32'h0);
        check("udf_sticky",   32'(udf),   32'd1);
        pop_chk("udf_cmt_pop", 32'h04030201);
        do_reset();
        check("udf_clr", 32'(udf), 32'd0);

        // Basic assembly and commit latency
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        check("t1_pre_empty", 32'(empty), 32'd1);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        check("t1_used",  32'(used),  32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_q_hold", q, 32'h0);
        pop_chk("t1_q", 32'h44332211);
        check("t1_empty_after", 32'(empty), 32'd1);

        // Flush with padding, flush with coincident write, and idle flush no-op
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_used", 32'(used), 32'd1);
        pop_chk("t2_q_ab", 32'h0000BBAA);
        cyc(1'b1, 8'hDD, 1'b0, 1'b0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b0);
        check("t2_used2", 32'(used), 32'd1);
        pop_chk("t2_q_cd", 32'h0000CCDD);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_noop", 32'(used), 32'd0);

        // Simultaneous commit and pop mid-range
        push_word(32'd1);
        push_word(32'd2);
        push_word(32'd3);
        check("t5_used3", 32'(used), 32'd3);
        cyc(1'b1, 8'h04, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        check("t5_used_same", 32'(used), 32'd3);
        check("t5_q", q, 32'd1);
        pop_chk("t5_pop2", 32'd2);
        pop_chk("t5_pop3", 32'd3);
        pop_chk("t5_pop4", 32'd4);
        check("t5_empty", 32'(empty), 32'd1);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) push_word(32'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_used", 32'(used), 32'd16);
        push_word(32'hEEEE_EEEE);
        check("t3_ovf",       32'(ovf),  32'd1);
        check("t3_used_ovf",  32'(used), 32'd16);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("t3_pop%0d", i), 32'(i));
        check("t3_empty",   32'(empty), 32'd1);
        check("t3_notfull", 32'(full),  32'd0);
        push_word(32'h1234_5678);
        pop_chk("t3_lane_clr", 32'h1234_5678);

        // Commit and pop together at full: accepted, no overflow
        do_reset();
        for (int i = 0; i < 16; i++) push_word(32'h20 + 32'(i));
        cyc(1'b1, 8'h30, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        check("t5f_used_pre", 32'(used), 32'd16);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        check("t5f_used", 32'(used), 32'd16);
        check("t5f_ovf",  32'(ovf),  32'd0);
        check("t5f_full", 32'(full), 32'd1);
        check("t5f_q",    q,         32'h20);
        for (int i = 1; i < 17; i++) pop_chk($sformatf("t5f_pop%0d", i), 32'h20 + 32'(i));
        check("t5f_empty", 32'(empty), 32'd1);

        // Show-ahead instance
        s_rst = 1'b0;
        s_cyc(1'b1, 8'hEF, 1'b0);
        s_cyc(1'b1, 8'hBE, 1'b0);
        s_cyc(1'b1, 8'hAD, 1'b0);
        check("t6_pre_empty", 32'(s_empty), 32'd1);
        s_cyc(1'b1, 8'hDE, 1'b0);
        check("t6_q",     s_q,           32'hDEADBEEF);
        check("t6_empty", 32'(s_empty),  32'd0);
        s_cyc(1'b0, 8'h00, 1'b1);
        check("t6_empty_pop", 32'(s_empty), 32'd1);
        check("t6_q_hold",    s_q,          32'hDEADBEEF);
        s_cyc(1'b1, 8'h01, 1'b0);
        s_cyc(1'b1, 8'h02, 1'b0);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        check("t6_rst_empty", 32'(s_empty), 32'd1);
        check("t6_rst_q",     s_q,          32'h0);
        s_cyc(1'b1, 8'h55, 1'b0);
        s_cyc(1'b1, 8'h66, 1'b0);
        s_cyc(1'b1, 8'h77, 1'b0);
        s_cyc(1'b1, 8'h88, 1'b0);
        check("t6_lane0", s_q,          32'h88776655);
        check("t6_used",  32'(s_used),  32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
